// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates the single unified memory port between fetch and data
//            stages; one outstanding valid/ready transaction, data has priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_kill,
    output logic [31:0]     if_rdata,
    output logic            if_done,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [2:0]      dm_funct3,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_done,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IF_REQ  = 3'd1,
        S_IF_WAIT = 3'd2,
        S_DM_REQ  = 3'd3,
        S_DM_WAIT = 3'd4
    } state_t;

    localparam logic [2:0] C_FETCH_SIZE = 3'b010;

    state_t            state_q, state_d;
    logic              kill_q, kill_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                // A req is still high during its own done cycle; masking it
                // there prevents a duplicate issue.
                if (dm_req && !dm_done_q) begin
                    state_d = S_DM_REQ;
                    valid_d = 1'b1;
                    we_d    = dm_we;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    size_d  = dm_funct3;
                end else if (if_req && !if_done_q) begin
                    state_d = S_IF_REQ;
                    valid_d = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    size_d  = C_FETCH_SIZE;
                end
            end
            S_IF_REQ: begin
                if (if_kill) kill_d = 1'b1;
                if (mem_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IF_WAIT;
                end
            end
            S_IF_WAIT: begin
                if (if_kill) kill_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                    // Killed fetches still drain the port but leave no trace.
                    if (!(kill_q || if_kill)) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata[31:0];
                    end
                end
            end
            S_DM_REQ: begin
                if (mem_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DM_WAIT;
                end
            end
            S_DM_WAIT: begin
                if (mem_rvalid) begin
                    state_d    = S_IDLE;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    assign mem_valid = valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_req & ~dm_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req, if_kill;
    logic [XLEN-1:0] if_addr;
    logic [31:0]     if_rdata;
    logic            if_done;
    logic            dm_req, dm_we;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic [2:0]      dm_funct3;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_done, stall_if, stall_mem;
    logic            mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]      mem_size;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_kill = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        check("rst_valid", mem_valid, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_size",  mem_size, 0);
        check("rst_we",    mem_we, 0);
        check("rst_done",  {if_done, dm_done}, 0);
        check("rst_rdata", {if_rdata, dm_rdata[31:0]}, 0);
        reset = 1'b0;
        // Stray rvalid while idle must be ignored.
        mem_rvalid = 1; mem_rdata = 64'hBAD;
        tick();
        mem_rvalid = 0;
        tick();
        check("stray_rv_done", {if_done, dm_done}, 0);
        check("stray_rv_rdata", dm_rdata, 0);

        // ---------------- Single fetch ----------------
        if_req = 1; if_addr = 64'h1000; mem_ready = 1;
        #1 check("sf_stall_c0", stall_if, 1);
        tick();                                   // c1
        check("sf_valid_c1", mem_valid, 1);
        check("sf_addr",  mem_addr, 64'h1000);
        check("sf_size",  mem_size, 3'b010);
        check("sf_we",    mem_we, 0);
        check("sf_wdata", mem_wdata, 0);
        check("sf_stall_c1", stall_if, 1);
        tick();                                   // c2
        check("sf_valid_c2", mem_valid, 0);
        check("sf_done_c2", if_done, 0);
        check("sf_stall_c2", stall_if, 1);
        mem_rvalid = 1; mem_rdata = 64'h0000_0000_0050_0093;
        tick();                                   // c3
        check("sf_done_c3", if_done, 1);
        check("sf_rdata", if_rdata, 32'h0050_0093);
        check("sf_stall_c3", stall_if, 0);
        mem_rvalid = 0;
        tick();                                   // c4: req still high at edge 3
        check("noreissue_c4", mem_valid, 0);
        check("sf_done_c4", if_done, 0);
        if_req = 0;
        tick();
        check("noreissue_c5", mem_valid, 0);

        // ---------------- Contention ----------------
        if_req = 1; if_addr = 64'h3000;
        dm_req = 1; dm_we = 0; dm_addr = 64'h2000; dm_funct3 = 3'b011;
        tick();                                   // c1
        check("ct_dm_first", mem_addr, 64'h2000);
        check("ct_dm_size", mem_size, 3'b011);
        check("ct_dm_valid", mem_valid, 1);
        check("ct_stall_mem", stall_mem, 1);
        tick();                                   // c2
        mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_0000_0013;
        tick();                                   // c3
        check("ct_dm_done", dm_done, 1);
        check("ct_dm_rdata", dm_rdata, 64'hAAAA_BBBB_0000_0013);
        check("ct_if_not_yet", mem_valid, 0);
        mem_rvalid = 0;
        tick();                                   // c4
        dm_req = 0;
        check("ct_if_issue", mem_valid, 1);
        check("ct_if_addr", mem_addr, 64'h3000);
        check("ct_if_size", mem_size, 3'b010);
        check("ct_dm_done_c4", dm_done, 0);
        tick();                                   // c5
        mem_rvalid = 1; mem_rdata = 64'h1234_5678_0000_0297;
        tick();                                   // c6
        check("ct_if_done", if_done, 1);
        check("ct_if_rdata", if_rdata, 32'h0000_0297);
        mem_rvalid = 0;
        tick();
        if_req = 0;
        tick();
        check("ct_idle", mem_valid, 0);

        // ---------------- Backpressure store ----------------
        mem_ready = 0;
        dm_req = 1; dm_we = 1; dm_addr = 64'h4000; dm_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        dm_funct3 = 3'b011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", mem_valid, 1);
            check("bp_addr",  mem_addr, 64'h4000);
            check("bp_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            check("bp_we",    mem_we, 1);
            check("bp_stall", stall_mem, 1);
        end
        mem_ready = 1;
        tick();
        check("bp_accepted", mem_valid, 0);
        check("bp_no_early_done", dm_done, 0);
        mem_rvalid = 1; mem_rdata = 64'h55;
        tick();
        check("bp_done", dm_done, 1);
        check("bp_rdata", dm_rdata, 64'h55);
        mem_rvalid = 0;
        tick();
        dm_req = 0; dm_we = 0;
        check("bp_done_pulse", dm_done, 0);
        tick();

        // ---------------- Kill in IF_WAIT ----------------
        if_req = 1; if_addr = 64'h5000;
        tick();                                   // c1
        check("kl_valid", mem_valid, 1);
        tick();                                   // c2: IF_WAIT
        if_kill = 1;
        tick();                                   // c3
        if_kill = 0;
        mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF;
        tick();                                   // c4: back in IDLE
        mem_rvalid = 0;
        check("kl_no_done", if_done, 0);
        check("kl_rdata_kept", if_rdata, 32'h0000_0297);
        check("kl_stall", stall_if, 1);
        check("kl_idle", mem_valid, 0);
        if_addr = 64'h6000;
        tick();                                   // c5
        check("kl_reissue", mem_valid, 1);
        check("kl_new_addr", mem_addr, 64'h6000);
        tick();
        mem_rvalid = 1; mem_rdata = 64'h0000_0517;
        tick();
        check("kl_next_done", if_done, 1);
        check("kl_next_rdata", if_rdata, 32'h0000_0517);
        mem_rvalid = 0;
        tick();
        if_req = 0;
        tick();

        // ---------------- Reset in DM_REQ ----------------
        mem_ready = 0;
        dm_req = 1; dm_we = 0; dm_addr = 64'h7000; dm_funct3 = 3'b010;
        tick();
        check("rs_valid_pre", mem_valid, 1);
        reset = 1;
        tick();
        check("rs_valid", mem_valid, 0);
        check("rs_addr",  mem_addr, 0);
        check("rs_size",  mem_size, 0);
        check("rs_rdata", {if_rdata, dm_rdata[31:0]}, 0);
        check("rs_done",  {if_done, dm_done}, 0);
        reset = 0; dm_req = 0; mem_ready = 1;
        tick();
        check("rs_after_done", dm_done, 0);
        check("rs_after_valid", mem_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
